// File: rtl/otbn_pq_bfu_pipe_if.sv
// Handshake and operand bundle for the multi-lane PQ butterfly unit.
// The master side issues operations and consumes results; the unit is the slave.
interface otbn_pq_bfu_pipe_if #(
   parameter int unsigned PqLen    = 32,
   parameter int unsigned NumLanes = 8,
   parameter int unsigned OpW      = 3
);
   logic                         in_valid_i;
   logic                         in_ready_o;
   logic [OpW-1:0]               op_i;
   logic [NumLanes*PqLen-1:0]    operand_a_i;
   logic [NumLanes*PqLen-1:0]    operand_b_i;
   logic [NumLanes*PqLen-1:0]    twiddle_i;
   logic [PqLen-1:0]             prime_i;
   logic [PqLen-1:0]             prime_dash_i;
   logic [3:0]                   tag_i;
   logic                         flush_i;
   logic                         out_valid_o;
   logic                         out_ready_i;
   logic [NumLanes*PqLen-1:0]    result_a_o;
   logic [NumLanes*PqLen-1:0]    result_b_o;
   logic [3:0]                   tag_o;

   modport master (
      output in_valid_i, op_i, operand_a_i, operand_b_i, twiddle_i, prime_i, prime_dash_i,
             tag_i, flush_i, out_ready_i,
      input  in_ready_o, out_valid_o, result_a_o, result_b_o, tag_o
   );

   modport slave (
      input  in_valid_i, op_i, operand_a_i, operand_b_i, twiddle_i, prime_i, prime_dash_i,
             tag_i, flush_i, out_ready_i,
      output in_ready_o, out_valid_o, result_a_o, result_b_o, tag_o
   );
endinterface

// File: rtl/otbn_pq_bfu_pipe.sv
// Pipelined multi-lane Montgomery butterfly unit: add/sub/mul/CT/GS per lane,
// fixed 3-edge latency, valid/ready backpressure and synchronous flush.
module otbn_pq_bfu_pipe #(
   parameter int unsigned PqLen    = 32,
   parameter int unsigned NumLanes = 8,
   parameter int unsigned OpW      = 3
) (
   input logic               clk_i,
   input logic               rst_ni,
   otbn_pq_bfu_pipe_if.slave bus
);
   localparam int unsigned VecW = NumLanes * PqLen;
   localparam int unsigned ProdW = 2 * PqLen;

   localparam logic [OpW-1:0] OpAdd = OpW'(0);
   localparam logic [OpW-1:0] OpSub = OpW'(1);
   localparam logic [OpW-1:0] OpMul = OpW'(2);
   localparam logic [OpW-1:0] OpCt  = OpW'(3);
   localparam logic [OpW-1:0] OpGs  = OpW'(4);

   function automatic logic [PqLen-1:0] add_mod(input logic [PqLen-1:0] a, b, q);
      logic [PqLen:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, q}) s = s - {1'b0, q};
      return s[PqLen-1:0];
   endfunction

   function automatic logic [PqLen-1:0] sub_mod(input logic [PqLen-1:0] a, b, q);
      logic [PqLen:0] d;
      d = {1'b0, a} - {1'b0, b};
      if (d[PqLen]) d = d + {1'b0, q};
      return d[PqLen-1:0];
   endfunction

   // u = (t + m*q) / R is below 2q, so one conditional subtraction reduces it.
   function automatic logic [PqLen-1:0] mont_red(input logic [ProdW-1:0] t,
                                                 input logic [PqLen-1:0] m, q);
      logic [ProdW-1:0] mq;
      logic [ProdW:0]   s;
      logic [PqLen:0]   u;
      mq = {{PqLen{1'b0}}, m} * {{PqLen{1'b0}}, q};
      s  = {1'b0, t} + {1'b0, mq};
      u  = s[ProdW:PqLen];
      if (u >= {1'b0, q}) u = u - {1'b0, q};
      return u[PqLen-1:0];
   endfunction

   logic w_stall;

   logic                      r_s1_valid, r_s2_valid, r_s3_valid, r_out_valid;
   logic [OpW-1:0]            r_s1_op, r_s2_op, r_s3_op;
   logic [3:0]                r_s1_tag, r_s2_tag, r_s3_tag, r_out_tag;
   logic [PqLen-1:0]          r_s1_q, r_s2_q, r_s3_q, r_s1_qd, r_s2_qd;
   logic [VecW-1:0]           r_s1_pre, r_s2_pre, r_s3_pre, r_s1_x, r_s1_y, r_s3_m;
   logic [NumLanes*ProdW-1:0] r_s2_t, r_s3_t;
   logic [VecW-1:0]           r_res_a, r_res_b;

   logic [VecW-1:0]           w_s1_pre, w_s1_x, w_s1_y, w_s2_m, w_res_a, w_res_b;
   logic [NumLanes*ProdW-1:0] w_s1_t;

   assign w_stall        = r_out_valid && !bus.out_ready_i;
   assign bus.in_ready_o = !w_stall;
   assign bus.out_valid_o = r_out_valid;
   assign bus.result_a_o = r_res_a;
   assign bus.result_b_o = r_res_b;
   assign bus.tag_o      = r_out_tag;

   // S1 input side: pre-add/sub and multiplier operand selection.
   always_comb begin
      logic [PqLen-1:0] la, lb, lw;
      w_s1_pre = '0;
      w_s1_x   = '0;
      w_s1_y   = '0;
      la = '0;
      lb = '0;
      lw = '0;
      for (int k = 0; k < NumLanes; k++) begin
         la = bus.operand_a_i[k*PqLen +: PqLen];
         lb = bus.operand_b_i[k*PqLen +: PqLen];
         lw = bus.twiddle_i[k*PqLen +: PqLen];
         case (bus.op_i)
            OpAdd: w_s1_pre[k*PqLen +: PqLen] = add_mod(la, lb, bus.prime_i);
            OpSub: w_s1_pre[k*PqLen +: PqLen] = sub_mod(la, lb, bus.prime_i);
            OpMul: begin
               w_s1_x[k*PqLen +: PqLen] = la;
               w_s1_y[k*PqLen +: PqLen] = lw;
            end
            OpCt: begin
               w_s1_pre[k*PqLen +: PqLen] = la;
               w_s1_x[k*PqLen +: PqLen]   = lb;
               w_s1_y[k*PqLen +: PqLen]   = lw;
            end
            OpGs: begin
               w_s1_pre[k*PqLen +: PqLen] = add_mod(la, lb, bus.prime_i);
               w_s1_x[k*PqLen +: PqLen]   = sub_mod(la, lb, bus.prime_i);
               w_s1_y[k*PqLen +: PqLen]   = lw;
            end
            default: ;
         endcase
      end
   end

   // Products t and m are split over two stages to avoid chaining multipliers.
   always_comb begin
      w_s1_t = '0;
      w_s2_m = '0;
      for (int k = 0; k < NumLanes; k++) begin
         w_s1_t[k*ProdW +: ProdW] = {{PqLen{1'b0}}, r_s1_x[k*PqLen +: PqLen]} *
                                    {{PqLen{1'b0}}, r_s1_y[k*PqLen +: PqLen]};
         w_s2_m[k*PqLen +: PqLen] = r_s2_t[k*ProdW +: PqLen] * r_s2_qd;
      end
   end

   always_comb begin
      logic [PqLen-1:0] red, pre;
      w_res_a = '0;
      w_res_b = '0;
      red = '0;
      pre = '0;
      for (int k = 0; k < NumLanes; k++) begin
         red = mont_red(r_s3_t[k*ProdW +: ProdW], r_s3_m[k*PqLen +: PqLen], r_s3_q);
         pre = r_s3_pre[k*PqLen +: PqLen];
         case (r_s3_op)
            OpAdd, OpSub: w_res_a[k*PqLen +: PqLen] = pre;
            OpMul:        w_res_a[k*PqLen +: PqLen] = red;
            OpCt: begin
               w_res_a[k*PqLen +: PqLen] = add_mod(pre, red, r_s3_q);
               w_res_b[k*PqLen +: PqLen] = sub_mod(pre, red, r_s3_q);
            end
            OpGs: begin
               w_res_a[k*PqLen +: PqLen] = pre;
               w_res_b[k*PqLen +: PqLen] = red;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_s1_valid <= 1'b0;  r_s2_valid <= 1'b0;  r_s3_valid <= 1'b0;  r_out_valid <= 1'b0;
         r_s1_op    <= '0;    r_s2_op    <= '0;    r_s3_op    <= '0;
         r_s1_tag   <= '0;    r_s2_tag   <= '0;    r_s3_tag   <= '0;    r_out_tag   <= '0;
         r_s1_q     <= '0;    r_s2_q     <= '0;    r_s3_q     <= '0;
         r_s1_qd    <= '0;    r_s2_qd    <= '0;
         r_s1_pre   <= '0;    r_s2_pre   <= '0;    r_s3_pre   <= '0;
         r_s1_x     <= '0;    r_s1_y     <= '0;    r_s3_m     <= '0;
         r_s2_t     <= '0;    r_s3_t     <= '0;
         r_res_a    <= '0;    r_res_b    <= '0;
      end else begin
         // Flush wins over stall so a stalled output is squashed too.
         if (bus.flush_i) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s3_valid  <= 1'b0;
            r_out_valid <= 1'b0;
         end else if (!w_stall) begin
            r_s1_valid  <= bus.in_valid_i;
            r_s2_valid  <= r_s1_valid;
            r_s3_valid  <= r_s2_valid;
            r_out_valid <= r_s3_valid;
         end
         if (!w_stall) begin
            r_s1_op  <= bus.op_i;         r_s1_tag <= bus.tag_i;
            r_s1_q   <= bus.prime_i;      r_s1_qd  <= bus.prime_dash_i;
            r_s1_pre <= w_s1_pre;         r_s1_x   <= w_s1_x;       r_s1_y <= w_s1_y;
            r_s2_op  <= r_s1_op;          r_s2_tag <= r_s1_tag;
            r_s2_q   <= r_s1_q;           r_s2_qd  <= r_s1_qd;
            r_s2_pre <= r_s1_pre;         r_s2_t   <= w_s1_t;
            r_s3_op  <= r_s2_op;          r_s3_tag <= r_s2_tag;     r_s3_q <= r_s2_q;
            r_s3_pre <= r_s2_pre;         r_s3_t   <= r_s2_t;       r_s3_m <= w_s2_m;
            r_out_tag <= r_s3_tag;
            r_res_a   <= w_res_a;
            r_res_b   <= w_res_b;
         end
      end
   end
endmodule

// File: tb/tb_otbn_pq_bfu_pipe.sv
// Self-checking bench: vector table plus scoreboard, with directed stall,
// flush and reset sequences.
module tb_otbn_pq_bfu_pipe;
   localparam int unsigned PqLen    = 32;
   localparam int unsigned NumLanes = 8;
   localparam int unsigned OpW      = 3;
   localparam int unsigned VecW     = NumLanes * PqLen;
   localparam int unsigned NumVec   = 24;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   otbn_pq_bfu_pipe_if #(.PqLen(PqLen), .NumLanes(NumLanes), .OpW(OpW)) bus ();

   otbn_pq_bfu_pipe #(.PqLen(PqLen), .NumLanes(NumLanes), .OpW(OpW)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   typedef struct {
      logic [OpW-1:0]  op;
      logic [VecW-1:0] a, b, w;
      logic [31:0]     q;
      logic [VecW-1:0] ea, eb;
   } vec_t;

   typedef struct {
      logic [3:0]      tag;
      logic [VecW-1:0] ea, eb;
      int              acc;
      bit              lat;
   } exp_t;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   exp_t sb[$];
   logic [VecW-1:0] cur_ea, cur_eb;
   bit cur_lat;
   vec_t tbl[NumVec];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic longint unsigned modpow(input longint unsigned b, e, m);
      longint unsigned r = 1;
      b = b % m;
      while (e != 0) begin
         if (e[0]) r = (r * b) % m;
         b = (b * b) % m;
         e = e >> 1;
      end
      return r;
   endfunction

   // Reference Montgomery product via an explicit R^-1 mod q (q prime).
   function automatic longint unsigned mref(input longint unsigned x, y, q);
      longint unsigned rinv;
      rinv = modpow((64'd1 << 32) % q, q - 2, q);
      return (((x * y) % q) * rinv) % q;
   endfunction

   function automatic logic [31:0] qdash(input logic [31:0] q);
      logic [31:0] inv;
      inv = q;
      repeat (5) inv = inv * (32'd2 - q * inv);
      return -inv;
   endfunction

   function automatic logic [VecW-1:0] rep(input logic [31:0] v);
      logic [VecW-1:0] r;
      for (int k = 0; k < NumLanes; k++) r[k*32 +: 32] = v;
      return r;
   endfunction

   function automatic void model(input logic [OpW-1:0] op, input logic [VecW-1:0] a, b, w,
                                 input longint unsigned q,
                                 output logic [VecW-1:0] ea, output logic [VecW-1:0] eb);
      longint unsigned la, lb, lw, ra, rb, p;
      ea = '0;
      eb = '0;
      for (int k = 0; k < NumLanes; k++) begin
         la = 64'(a[k*32 +: 32]);
         lb = 64'(b[k*32 +: 32]);
         lw = 64'(w[k*32 +: 32]);
         ra = 0;
         rb = 0;
         case (op)
            3'd0: ra = (la + lb) % q;
            3'd1: ra = (la + q - lb) % q;
            3'd2: ra = mref(la, lw, q);
            3'd3: begin
               p  = mref(lb, lw, q);
               ra = (la + p) % q;
               rb = (la + q - p) % q;
            end
            3'd4: begin
               ra = (la + lb) % q;
               rb = mref((la + q - lb) % q, lw, q);
            end
            default: ;
         endcase
         ea[k*32 +: 32] = ra[31:0];
         eb[k*32 +: 32] = rb[31:0];
      end
   endfunction

   task automatic chk_bit(input string name, input logic got, input logic exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic chk_vec(input string name, input logic [VecW-1:0] got, input logic [VecW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Scoreboard monitor, sampling mid-cycle.
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n) begin
         if (bus.out_valid_o && bus.out_ready_i) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_output: got tag %0d with nothing outstanding", bus.tag_o);
            end else begin
               e = sb.pop_front();
               if (bus.result_a_o !== e.ea || bus.result_b_o !== e.eb || bus.tag_o !== e.tag) begin
                  n_fail++;
                  $display("FAIL result: got tag %0d a=%h b=%h expected tag %0d a=%h b=%h",
                           bus.tag_o, bus.result_a_o, bus.result_b_o, e.tag, e.ea, e.eb);
               end
               if (e.lat) begin
                  n_cmp++;
                  if (cyc - e.acc != 4) begin
                     n_fail++;
                     $display("FAIL latency tag %0d: got %0d edges expected 3", e.tag,
                              cyc - e.acc - 1);
                  end
               end
            end
         end
         if (bus.flush_i) sb.delete();
         else if (bus.in_valid_i && bus.in_ready_o)
            sb.push_back('{tag: bus.tag_i, ea: cur_ea, eb: cur_eb, acc: cyc, lat: cur_lat});
      end
   end

   task automatic drive(input logic [OpW-1:0] op, input logic [VecW-1:0] a, b, w,
                        input logic [31:0] q, input logic [3:0] tag,
                        input logic [VecW-1:0] ea, eb, input bit lat);
      bus.in_valid_i   = 1'b1;
      bus.op_i         = op;
      bus.operand_a_i  = a;
      bus.operand_b_i  = b;
      bus.twiddle_i    = w;
      bus.prime_i      = q;
      bus.prime_dash_i = qdash(q);
      bus.tag_i        = tag;
      cur_ea  = ea;
      cur_eb  = eb;
      cur_lat = lat;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_vec(input int i, input logic [3:0] tag, input bit lat);
      drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].w, tbl[i].q, tag, tbl[i].ea, tbl[i].eb, lat);
   endtask

   task automatic idle(input int n);
      bus.in_valid_i = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain(input string name);
      bus.in_valid_i = 1'b0;
      for (int i = 0; i < 60 && sb.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL %s drain: got %0d outstanding expected 0", name, sb.size());
      end
      idle(2);
   endtask

   task automatic wait_out_valid(input string name);
      int i;
      for (i = 0; i < 10 && !bus.out_valid_o; i++) begin
         @(posedge clk);
         #1;
      end
      chk_bit({name, "_out_valid"}, bus.out_valid_o, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] q;
      logic [VecW-1:0] a, b, w;
      bus.in_valid_i = 1'b0;  bus.op_i = '0;         bus.operand_a_i = '0;
      bus.operand_b_i = '0;   bus.twiddle_i = '0;    bus.prime_i = 32'd3329;
      bus.prime_dash_i = '0;  bus.tag_i = '0;        bus.flush_i = 1'b0;
      bus.out_ready_i = 1'b1;
      cur_ea = '0;  cur_eb = '0;  cur_lat = 1'b0;

      tbl[0] = '{3'd0, rep(3000), rep(500),  rep(0),    32'd3329, rep(171),  rep(0)};
      tbl[1] = '{3'd1, rep(5),    rep(10),   rep(0),    32'd3329, rep(3324), rep(0)};
      tbl[2] = '{3'd2, rep(1234), rep(0),    rep(1353), 32'd3329, rep(1234), rep(0)};
      tbl[3] = '{3'd3, rep(100),  rep(3000), rep(1353), 32'd3329, rep(3100), rep(429)};
      tbl[4] = '{3'd4, rep(100),  rep(3000), rep(1353), 32'd3329, rep(3100), rep(429)};
      tbl[5] = '{3'd7, rep(100),  rep(200),  rep(1353), 32'd3329, rep(0),    rep(0)};
      for (int i = 6; i < NumVec; i++) begin
         q = (i % 2 == 0) ? 32'd3329 : 32'd8380417;
         for (int k = 0; k < NumLanes; k++) begin
            a[k*32 +: 32] = $urandom_range(0, q - 1);
            b[k*32 +: 32] = $urandom_range(0, q - 1);
            w[k*32 +: 32] = $urandom_range(0, q - 1);
         end
         tbl[i].op = 3'(i % 5);
         tbl[i].a  = a;
         tbl[i].b  = b;
         tbl[i].w  = w;
         tbl[i].q  = q;
         model(tbl[i].op, a, b, w, 64'(q), tbl[i].ea, tbl[i].eb);
      end

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk_bit("rst_out_valid", bus.out_valid_o, 1'b0);
      chk_bit("rst_in_ready", bus.in_ready_o, 1'b1);
      chk_vec("rst_result_a", bus.result_a_o, '0);
      chk_vec("rst_result_b", bus.result_b_o, '0);
      chk_vec("rst_tag", VecW'(bus.tag_o), '0);
      rst_n = 1'b1;
      idle(2);

      // Back-to-back Add, tags 0..15, one result per cycle
      for (int i = 0; i < 16; i++) drive(3'd0, rep(3000), rep(500), rep(0), 32'd3329, 4'(i),
                                         rep(171), rep(0), 1'b1);
      wait_drain("throughput");

      for (int i = 0; i < NumVec; i++) drive_vec(i, 4'(i), 1'b1);
      wait_drain("table");

      // Backpressure: 3 in flight, 5 stalled cycles, then accept + issue together
      bus.out_ready_i = 1'b0;
      drive_vec(3, 4'd1, 1'b0);
      drive_vec(4, 4'd2, 1'b0);
      drive_vec(2, 4'd3, 1'b0);
      idle(0);
      wait_out_valid("stall");
      for (int i = 0; i < 5; i++) begin
         chk_bit("stall_in_ready", bus.in_ready_o, 1'b0);
         chk_vec("stall_hold_a", bus.result_a_o, tbl[3].ea);
         chk_vec("stall_hold_tag", VecW'(bus.tag_o), VecW'(4'd1));
         idle(1);
      end
      bus.out_ready_i = 1'b1;
      #1;
      chk_bit("release_in_ready", bus.in_ready_o, 1'b1);
      drive_vec(1, 4'd4, 1'b0);
      wait_drain("backpressure");

      // Flush with 3 in flight; same-cycle input is dropped
      drive_vec(0, 4'd5, 1'b0);
      drive_vec(1, 4'd6, 1'b0);
      drive_vec(3, 4'd7, 1'b0);
      bus.flush_i = 1'b1;
      drive_vec(4, 4'd8, 1'b0);
      bus.flush_i = 1'b0;
      bus.in_valid_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk_bit("flush_out_valid", bus.out_valid_o, 1'b0);
         idle(1);
      end
      wait_drain("flush");

      // Flush squashes a stalled output
      bus.out_ready_i = 1'b0;
      drive_vec(2, 4'd9, 1'b0);
      idle(0);
      wait_out_valid("flush_stall");
      bus.flush_i = 1'b1;
      idle(1);
      bus.flush_i = 1'b0;
      chk_bit("flush_stall_out_valid", bus.out_valid_o, 1'b0);
      bus.out_ready_i = 1'b1;
      drive_vec(3, 4'd10, 1'b1);
      wait_drain("post_flush");

      // Asynchronous reset while a result is being presented
      drive_vec(0, 4'd11, 1'b0);
      drive_vec(1, 4'd12, 1'b0);
      drive_vec(2, 4'd13, 1'b0);
      drive_vec(3, 4'd14, 1'b0);
      bus.in_valid_i = 1'b0;
      #2;
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk_bit("arst_out_valid", bus.out_valid_o, 1'b0);
      chk_bit("arst_in_ready", bus.in_ready_o, 1'b1);
      chk_vec("arst_result_a", bus.result_a_o, '0);
      chk_vec("arst_result_b", bus.result_b_o, '0);
      chk_vec("arst_tag", VecW'(bus.tag_o), '0);
      idle(2);
      rst_n = 1'b1;
      idle(1);
      drive_vec(4, 4'd15, 1'b1);
      wait_drain("post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/otbn_pq_bfu_pipe.md
Name: otbn_pq_bfu_pipe

Overview:
- Parametrised, pipelined, multi-lane Montgomery butterfly unit for the OTBN PQ datapath. It generalises the single-lane 32-bit PQ ALU to NumLanes independent lanes of PqLen-bit coefficients.
- Fixed 3-cycle latency, valid/ready handshake with backpressure, and a synchronous flush.
- Sits between the PQ WDR read ports and the PQ writeback mux. One butterfly is issued per lane per cycle.

Parameters:
- PqLen, 32: coefficient width in bits; Montgomery radix R = 2^PqLen.
- NumLanes, 8: parallel lanes; 8 x 32 bits fills one 256-bit WDR.
- OpW, 3: width of the op_i encoding.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  operation valid.
- in_ready_o  out  1  unit can accept an operation this cycle.
- op_i  in  OpW  operation: 0 Add, 1 Sub, 2 Mul, 3 ButterflyCT, 4 ButterflyGS; 5-7 reserved.
- operand_a_i  in  NumLanes*PqLen  lane-packed a; lane k is bits [k*PqLen +: PqLen].
- operand_b_i  in  NumLanes*PqLen  lane-packed b.
- twiddle_i  in  NumLanes*PqLen  per-lane twiddle w.
- prime_i  in  PqLen  modulus q, shared by all lanes.
- prime_dash_i  in  PqLen  q' = -q^-1 mod R.
- tag_i  in  4  opaque tag (e.g. destination WDR index) carried through the pipeline.
- flush_i  in  1  synchronous squash of all in-flight operations.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- result_a_o  out  NumLanes*PqLen  primary result per lane.
- result_b_o  out  NumLanes*PqLen  secondary result per lane; 0 for Add, Sub, Mul.
- tag_o  out  4  tag of the current result.

Behaviour:
- Montgomery product: mont(x,y) = x*y*R^-1 mod q.
  - t = x*y, full 2*PqLen bits.
  - m = (t mod R)*q' mod R.
  - u = (t + m*q) >> PqLen, computed at 2*PqLen+1 bits.
  - Output is u - q if u >= q, else u.
- Modular add/sub use PqLen+1-bit intermediates with one conditional correction by q. All outputs are fully reduced to [0, q).
- Preconditions: q odd, q < 2^(PqLen-1), and a, b, w < q. If violated, outputs are unspecified but must be X-free.
- Per-lane results:
  - Add: A = a+b.
  - Sub: A = a-b.
  - Mul: A = mont(a,w).
  - CT: p = mont(b,w); A = a+p; B = a-p.
  - GS: A = a+b; B = mont(a-b, w).
  - Reserved op: A = B = 0; the op still flows through the pipeline and returns its tag.
- Pipeline stages:
  - S1: capture op, tag, q, q'; compute GS pre-add/sub; select the multiplier operands.
  - S2: register t and m.
  - S3: final reduction, CT post-add/sub, output registers.
- Latency: an operation accepted at edge N presents out_valid_o after edge N+3 when no stall occurs.
- q and q' are sampled at accept and travel with the operation. Changing them mid-stream does not corrupt in-flight results.
- Handshake and stalls:
  - stall = out_valid_o && !out_ready_i.
  - in_ready_o = !stall. This is combinational, with no dependency on in_valid_i.
  - During a stall, all stage registers hold.
  - Bubbles are not collapsed; throughput is one operation per cycle when out_ready_i is held high.
- Transfer rules: input transfers on in_valid_i && in_ready_o. Output transfers on out_valid_o && out_ready_i. Output data and tag are stable while out_valid_o is high and not accepted.
- Simultaneous output accept and new input in one cycle: both transfer and the pipeline advances.
- Flush:
  - flush_i clears all stage valid bits at the next edge, including an output being stalled.
  - An input presented in the same cycle as flush_i is discarded.
  - Data registers need not clear.
  - Flush has priority over stall.
- Reset: all valid bits 0, out_valid_o = 0, result_a_o = result_b_o = 0, tag_o = 0, in_ready_o = 1.
- Reset asserted mid-operation discards all in-flight work with no partial output.
- Lanes are fully independent; no carry crosses a lane boundary.

Test Plan:
- Reset and throughput:
  - Reset, then drive Add every cycle with out_ready_i = 1, NumLanes = 8, q = 3329.
  - Lane 0: a = 3000, b = 500 gives A = 171.
  - out_valid_o rises 3 cycles after the first accept, then results appear one per cycle in tag order 0..15.
- Sub wrap-around:
  - a = 5, b = 10, q = 3329 gives A = 3324, B = 0 on all lanes.
- Mul identity:
  - w = R mod q = 1353, q' = -3329^-1 mod 2^32 (bench-computed), a = 1234 gives A = 1234.
  - Random a and w checked against a bench-side reference model.
- Butterflies:
  - w = 1353, a = 100, b = 3000.
  - CT gives A = 3100, B = 429.
  - GS gives A = 3100, B = 429.
  - Per-lane distinct twiddles checked against the reference model.
- Backpressure:
  - Hold out_ready_i = 0 for 5 cycles with 3 operations in flight.
  - in_ready_o = 0, output stable, no loss or duplication; all 3 drain in order after release.
  - Same-cycle output accept plus new input accepted.
- Flush and reset:
  - flush_i with 3 operations in flight: out_valid_o = 0 next cycle and no stale tag ever appears.
  - Assert rst_ni low mid-stream: outputs 0 immediately (asynchronous); the first operation after reset has 3-cycle latency.
